// File: rtl/puf_launch_capture.sv
// Launch/capture controller for an arbiter-PUF delay chain: races the chain N_TRIALS times
// per challenge and majority-votes one response bit. Optional tie counter: PUF_TIE_COUNT_EN.
module puf_launch_capture #(
    parameter int  N_STAGES = 64,
    parameter int  N_TRIALS = 15,
    parameter int  MAX_WAIT = 16,
    parameter int  RECOVER  = 4,
    localparam int CNT_W    = $clog2(N_TRIALS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_STAGES-1:0] challenge,
    output logic [N_STAGES-1:0] sel_o,
    output logic                launch_o,
    input  logic                path_top_i,
    input  logic                path_bot_i,
    output logic                busy,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                response,
    output logic [CNT_W-1:0]    ones_cnt,
    output logic                timeout_err,
    output logic [2:0]          dbg_state_o
`ifdef PUF_TIE_COUNT_EN
    ,
    output logic [CNT_W-1:0]    tie_cnt
`endif
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int REC_W  = $clog2(RECOVER + 1);
    localparam logic [CNT_W-1:0]  TRIALS_C = CNT_W'(N_TRIALS);
    localparam logic [CNT_W-1:0]  HALF_C   = CNT_W'(N_TRIALS / 2);
    localparam logic [WAIT_W-1:0] WAIT_C   = WAIT_W'(MAX_WAIT);
    localparam logic [REC_W-1:0]  REC_LAST = REC_W'(RECOVER - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        LAUNCH  = 3'd2,
        RACE    = 3'd3,
        RECOV   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [N_STAGES-1:0] sel_q, sel_d;
    logic                launch_q, launch_d;
    logic                top_q, bot_q;
    logic [CNT_W-1:0]    ones_q, ones_d;
    logic [CNT_W-1:0]    trial_q, trial_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [REC_W-1:0]    rec_q, rec_d;
    logic                timeout_q, timeout_d;
    logic                resp_q, resp_d;
`ifdef PUF_TIE_COUNT_EN
    logic [CNT_W-1:0]    tie_q, tie_d;
`endif

    // Handshake: resp_valid rises on DONE entry and stays high, with response, ones_cnt and
    // timeout_err frozen, until the cycle in which resp_valid && resp_ready is sampled.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ones_d    = ones_q;
        trial_d   = trial_q;
        wait_d    = wait_q;
        rec_d     = rec_q;
        timeout_d = timeout_q;
        resp_d    = resp_q;
`ifdef PUF_TIE_COUNT_EN
        tie_d     = tie_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d     = challenge;
                    ones_d    = '0;
                    trial_d   = '0;
                    timeout_d = 1'b0;
                    resp_d    = 1'b0;
`ifdef PUF_TIE_COUNT_EN
                    tie_d     = '0;
`endif
                    state_d   = SETTLE;
                end
            end
            SETTLE: state_d = LAUNCH;
            LAUNCH: begin
                wait_d  = '0;
                state_d = RACE;
            end
            RACE: begin
                wait_d = wait_q + WAIT_W'(1);
                if (top_q && !bot_q) begin
                    ones_d  = ones_q + CNT_W'(1);
                    trial_d = trial_q + CNT_W'(1);
                    rec_d   = '0;
                    state_d = RECOV;
                end else if (bot_q) begin
                    // A tie (both paths seen in the same cycle) scores as a bottom win.
`ifdef PUF_TIE_COUNT_EN
                    if (top_q) tie_d = tie_q + CNT_W'(1);
`endif
                    trial_d = trial_q + CNT_W'(1);
                    rec_d   = '0;
                    state_d = RECOV;
                end else if (wait_d == WAIT_C) begin
                    timeout_d = 1'b1;
                    trial_d   = trial_q + CNT_W'(1);
                    rec_d     = '0;
                    state_d   = RECOV;
                end
            end
            RECOV: begin
                if (top_q || bot_q) begin
                    rec_d = '0;
                end else if (rec_q == REC_LAST) begin
                    rec_d = '0;
                    if (trial_q == TRIALS_C) begin
                        resp_d  = (ones_q > HALF_C);
                        state_d = DONE;
                    end else begin
                        state_d = LAUNCH;
                    end
                end else begin
                    rec_d = rec_q + REC_W'(1);
                end
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        launch_d = (state_d == LAUNCH) || (state_d == RACE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            launch_q  <= 1'b0;
            top_q     <= 1'b0;
            bot_q     <= 1'b0;
            ones_q    <= '0;
            trial_q   <= '0;
            wait_q    <= '0;
            rec_q     <= '0;
            timeout_q <= 1'b0;
            resp_q    <= 1'b0;
`ifdef PUF_TIE_COUNT_EN
            tie_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            launch_q  <= launch_d;
            top_q     <= path_top_i;
            bot_q     <= path_bot_i;
            ones_q    <= ones_d;
            trial_q   <= trial_d;
            wait_q    <= wait_d;
            rec_q     <= rec_d;
            timeout_q <= timeout_d;
            resp_q    <= resp_d;
`ifdef PUF_TIE_COUNT_EN
            tie_q     <= tie_d;
`endif
        end
    end

    assign sel_o       = sel_q;
    assign launch_o    = launch_q;
    assign busy        = (state_q != IDLE);
    assign resp_valid  = (state_q == DONE);
    assign response    = resp_q;
    assign ones_cnt    = ones_q;
    assign timeout_err = timeout_q;
    assign dbg_state_o = state_q;
`ifdef PUF_TIE_COUNT_EN
    assign tie_cnt     = tie_q;
`endif

endmodule

// File: tb/tb_puf_launch_capture.sv
// Bench for puf_launch_capture: a delay-chain responder plays a per-race outcome plan, and the
// expected vote is computed directly from that plan.
module tb_puf_launch_capture;

    localparam int N_STAGES = 64;
    localparam int N_TRIALS = 15;
    localparam int CNT_W    = $clog2(N_TRIALS + 1);

    // Race outcome codes used in the plan
    localparam int M_TOP = 0, M_BOT = 1, M_TIE = 2, M_TMO = 3, M_BOT_TOP = 4, M_TOP_BOT = 5;

    logic                clk = 1'b0;
    logic                rst, start, resp_ready, path_top_i, path_bot_i;
    logic [N_STAGES-1:0] challenge, sel_o;
    logic                launch_o, busy, resp_valid, response, timeout_err;
    logic [CNT_W-1:0]    ones_cnt;
    logic [2:0]          dbg_state;
`ifdef PUF_TIE_COUNT_EN
    logic [CNT_W-1:0]    tie_cnt;
`endif

    int          n_checks = 0;
    int          n_err    = 0;
    int          plan_q[$];
    int          plan_a[N_TRIALS];
    logic [0:0]  exp_q[$];

    puf_launch_capture dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .sel_o(sel_o),
        .launch_o(launch_o), .path_top_i(path_top_i), .path_bot_i(path_bot_i),
        .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .response(response), .ones_cnt(ones_cnt), .timeout_err(timeout_err),
        .dbg_state_o(dbg_state)
`ifdef PUF_TIE_COUNT_EN
        , .tie_cnt(tie_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Delay-chain responder: on each launch, takes the next planned outcome and raises the
    // winning path(s) 1..4 cycles later; both paths drop once launch falls.
    initial begin : chain_model
        int age, dly, mode;
        path_top_i = 1'b0;
        path_bot_i = 1'b0;
        age = 0; dly = 1; mode = M_TOP;
        forever begin
            @(posedge clk); #1;
            if (!launch_o) begin
                path_top_i = 1'b0;
                path_bot_i = 1'b0;
                age = 0;
            end else begin
                age++;
                if (age == 1) begin
                    mode = (plan_q.size() > 0) ? plan_q.pop_front() : M_TOP;
                    dly  = $urandom_range(1, 4);
                end
                if (age == dly) begin
                    case (mode)
                        M_TOP, M_TOP_BOT: path_top_i = 1'b1;
                        M_BOT, M_BOT_TOP: path_bot_i = 1'b1;
                        M_TIE: begin path_top_i = 1'b1; path_bot_i = 1'b1; end
                        default: ;
                    endcase
                end
                if (age == dly + 1) begin
                    case (mode)
                        M_BOT_TOP: path_top_i = 1'b1;
                        M_TOP_BOT: path_bot_i = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Runs one evaluation of the plan in plan_a; hold > 0 stalls the consumer that many
    // cycles while poking start with fresh challenges.
    task automatic run_eval(input logic [63:0] ch, input string tag, input int hold);
        int          e_ones, e_ties, cyc;
        logic        e_to;
        logic [0:0]  e_resp;
        logic [63:0] h_sel;
        logic [CNT_W-1:0] h_ones;
        logic        h_resp;
        e_ones = 0; e_ties = 0; e_to = 1'b0;
        for (int i = 0; i < N_TRIALS; i++) begin
            plan_q.push_back(plan_a[i]);
            if (plan_a[i] == M_TOP || plan_a[i] == M_TOP_BOT) e_ones++;
            if (plan_a[i] == M_TIE) e_ties++;
            if (plan_a[i] == M_TMO) e_to = 1'b1;
        end
        exp_q.push_back((e_ones > N_TRIALS / 2) ? 1'b1 : 1'b0);

        start = 1'b1;
        challenge = ch;
        tick();
        start = 1'b0;
        challenge = {$urandom, $urandom};
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_sel"}, sel_o, ch);

        cyc = 0;
        while (!resp_valid && cyc < 3000) begin
            tick();
            cyc++;
        end
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
        e_resp = exp_q.pop_front();
        check({tag, "_resp"}, 64'(response), 64'(e_resp));
        check({tag, "_ones"}, 64'(ones_cnt), 64'(e_ones));
        check({tag, "_tmo"}, 64'(timeout_err), 64'(e_to));
        check({tag, "_sel_held"}, sel_o, ch);
`ifdef PUF_TIE_COUNT_EN
        check({tag, "_ties"}, 64'(tie_cnt), 64'(e_ties));
`endif

        if (hold > 0) begin
            h_sel = sel_o; h_ones = ones_cnt; h_resp = response;
            for (int k = 0; k < hold; k++) begin
                start = (k % 2 == 0);
                challenge = {$urandom, $urandom};
                tick();
                check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
                check({tag, "_hold_out"}, {sel_o == h_sel, ones_cnt == h_ones, response == h_resp},
                      64'b111);
            end
            start = 1'b0;
        end

        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_valid"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin : main
        int cyc, v;
        rst = 1'b1; start = 1'b0; resp_ready = 1'b0; challenge = '0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_launch", 64'(launch_o), 64'd0);
        check("rst_outs", {sel_o == '0, ones_cnt == '0, response, timeout_err}, 64'b1100);
        rst = 1'b0;
        tick();

        for (int i = 0; i < N_TRIALS; i++) plan_a[i] = M_TOP;
        run_eval(64'hA5A5_0000_FFFF_1234, "all_top", 0);

        for (int i = 0; i < N_TRIALS; i++) plan_a[i] = (i < 7) ? M_TOP_BOT : M_BOT;
        run_eval({$urandom, $urandom}, "split7", 0);

        for (int i = 0; i < N_TRIALS; i++) plan_a[i] = (i % 2 == 0) ? M_TOP : M_BOT_TOP;
        run_eval({$urandom, $urandom}, "split8", 0);

        for (int i = 0; i < N_TRIALS; i++) plan_a[i] = M_TIE;
        run_eval({$urandom, $urandom}, "ties", 0);

        for (int i = 0; i < N_TRIALS; i++) plan_a[i] = M_TMO;
        run_eval({$urandom, $urandom}, "timeout", 0);

        for (int i = 0; i < N_TRIALS; i++) plan_a[i] = M_TOP;
        run_eval({$urandom, $urandom}, "handshake", 10);

        // Reset in the middle of a race
        for (int i = 0; i < N_TRIALS; i++) plan_a[i] = M_TMO;
        for (int i = 0; i < N_TRIALS; i++) plan_q.push_back(plan_a[i]);
        start = 1'b1; challenge = {$urandom, $urandom};
        tick();
        start = 1'b0;
        cyc = 0;
        while (!launch_o && cyc < 50) begin
            tick();
            cyc++;
        end
        check("mid_launch_seen", 64'(launch_o), 64'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_launch", 64'(launch_o), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(resp_valid), 64'd0);
        tick();
        rst = 1'b0;
        plan_q.delete();
        tick();

        // Randomized plans
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N_TRIALS; i++) begin
                v = $urandom_range(0, 9);
                case (v)
                    0, 1, 2: plan_a[i] = M_TOP;
                    3, 4, 5: plan_a[i] = M_BOT;
                    6:       plan_a[i] = M_TIE;
                    7:       plan_a[i] = M_BOT_TOP;
                    8:       plan_a[i] = M_TOP_BOT;
                    default: plan_a[i] = (r < 3) ? M_TOP : M_TMO;
                endcase
            end
            run_eval({$urandom, $urandom}, $sformatf("rand%0d", r), (r == 2) ? 3 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
